// File: rtl/uart_cmd_decoder_if.sv
// Bundle of UART RX/TX, board-button and control-strobe signals for uart_cmd_decoder.
// Pure wiring: no logic and no added latency.
// The TX side uses a start/busy handshake. The slave (decoder) holds tx_start off while tx_busy is high.
interface uart_cmd_decoder_if;
  // RX byte stream
  logic [7:0] rx_data;
  logic       rx_done;
  // debounced board buttons
  logic       btn_l;
  logic       btn_u;
  logic       btn_d;
  logic       btn_r;
  // TX handshake
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  // control strobes to the clock/stopwatch top
  logic       Btn_L_sw;
  logic       Btn_L_watch;
  logic       Btn_U;
  logic       Btn_D;
  logic       Btn_R;
  logic       uart_mode;
  logic       cmd_err;
  logic       ack_drop;

  // decoder side
  modport slave (
    input  rx_data, rx_done, btn_l, btn_u, btn_d, btn_r, tx_busy,
    output tx_data, tx_start, Btn_L_sw, Btn_L_watch, Btn_U, Btn_D, Btn_R,
           uart_mode, cmd_err, ack_drop
  );

  // environment side: UART core, buttons and consumers
  modport master (
    output rx_data, rx_done, btn_l, btn_u, btn_d, btn_r, tx_busy,
    input  tx_data, tx_start, Btn_L_sw, Btn_L_watch, Btn_U, Btn_D, Btn_R,
           uart_mode, cmd_err, ack_drop
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Decodes UART command bytes and board buttons into one-cycle control pulses, and returns one ACK byte per received byte.
// Latency: strobes appear 1 cycle after rx_done or a button; tx_start appears 2 cycles after rx_done at the earliest.
// Backpressure: the ACK waits in SEND while tx_busy is high; a byte arriving while an ACK is in flight still acts but its ACK is dropped.
module uart_cmd_decoder #(
  parameter bit   CASE_INSENS = 1'b1,
  parameter bit   ACK_EN      = 1'b1,
  parameter logic MODE_RST    = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  uart_cmd_decoder_if.slave     io
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // Registered outputs
  logic       r_btn_l_sw;
  logic       r_btn_l_watch;
  logic       r_btn_u;
  logic       r_btn_d;
  logic       r_btn_r;
  logic       r_mode;
  logic       r_cmd_err;
  logic       r_ack_drop;
  logic       r_tx_start;
  logic [7:0] r_tx_data;
  state_t     r_state;
  // Set on entry to WAIT so that WAIT lasts at least one cycle before tx_busy is looked at.
  logic       r_dwell;

  // Decode results for the current RX byte, each gated by rx_done
  logic [7:0] w_byte_uc;
  logic       w_rx_l;
  logic       w_rx_u;
  logic       w_rx_d;
  logic       w_rx_r;
  logic       w_rx_m;
  logic       w_known;
  logic       w_l_act;
  logic [7:0] w_ack;

  // Fold lowercase onto uppercase when allowed, then match the command letters
  always_comb begin
    w_byte_uc = io.rx_data;
    if (CASE_INSENS && (io.rx_data >= 8'h61) && (io.rx_data <= 8'h7A)) begin
      w_byte_uc = io.rx_data - 8'h20;
    end
    w_rx_l  = io.rx_done && (w_byte_uc == 8'h4C);
    w_rx_u  = io.rx_done && (w_byte_uc == 8'h55);
    w_rx_d  = io.rx_done && (w_byte_uc == 8'h44);
    w_rx_r  = io.rx_done && (w_byte_uc == 8'h52);
    w_rx_m  = io.rx_done && (w_byte_uc == 8'h4D);
    w_known = w_rx_l || w_rx_u || w_rx_d || w_rx_r || w_rx_m;
    // UART 'L' and the board button share one run/stop action, so they produce a single pulse
    w_l_act = w_rx_l || io.btn_l;
    // A recognised byte is echoed unchanged; anything else is answered with '?'
    w_ack   = w_known ? io.rx_data : 8'h3F;
  end

  // Control strobes and the mode level; the L action is routed by the mode held before this edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_btn_l_sw    <= 1'b0;
      r_btn_l_watch <= 1'b0;
      r_btn_u       <= 1'b0;
      r_btn_d       <= 1'b0;
      r_btn_r       <= 1'b0;
      r_cmd_err     <= 1'b0;
      r_mode        <= MODE_RST;
    end else begin
      r_btn_l_sw    <= w_l_act && !r_mode;
      r_btn_l_watch <= w_l_act && r_mode;
      r_btn_u       <= w_rx_u || io.btn_u;
      r_btn_d       <= w_rx_d || io.btn_d;
      r_btn_r       <= w_rx_r || io.btn_r;
      r_cmd_err     <= io.rx_done && !w_known;
      if (w_rx_m) begin
        r_mode <= !r_mode;
      end
    end
  end

  // ACK transmit FSM: load in IDLE, request in SEND once TX is free, then wait in WAIT for TX to finish
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_ack_drop <= 1'b0;
      r_dwell    <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_ack_drop <= 1'b0;
      if (ACK_EN) begin
        case (r_state)
          S_IDLE: begin
            if (io.rx_done) begin
              r_tx_data <= w_ack;
              r_state   <= S_SEND;
            end
          end
          S_SEND: begin
            if (io.rx_done) begin
              r_ack_drop <= 1'b1;
            end
            if (!io.tx_busy) begin
              r_tx_start <= 1'b1;
              r_dwell    <= 1'b1;
              r_state    <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (io.rx_done) begin
              r_ack_drop <= 1'b1;
            end
            if (r_dwell) begin
              r_dwell <= 1'b0;
            end else if (!io.tx_busy) begin
              r_state <= S_IDLE;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end else begin
        r_state <= S_IDLE;
      end
    end
  end

  assign io.Btn_L_sw    = r_btn_l_sw;
  assign io.Btn_L_watch = r_btn_l_watch;
  assign io.Btn_U       = r_btn_u;
  assign io.Btn_D       = r_btn_d;
  assign io.Btn_R       = r_btn_r;
  assign io.uart_mode   = r_mode;
  assign io.cmd_err     = r_cmd_err;
  assign io.ack_drop    = r_ack_drop;
  assign io.tx_start    = r_tx_start;
  assign io.tx_data     = r_tx_data;

endmodule
